// File: rtl/eqn_match_store.sv
// rtl/eqn_match_store.sv - debounced store/compare operand memory with a sequential match scan
// Buttons pass through a 2-flop synchroniser and a debouncer; stores made during a scan are buffered.

module eqn_match_store #(
   parameter int WIDTH    = 4,
   parameter int DEPTH    = 4,
   parameter int DEBOUNCE = 16,
   parameter int IDXW     = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] test,
   input  logic [1:0]       pushbutton,
   output logic             result,
   output logic             result_valid,
   output logic [IDXW-1:0]  match_idx,
   output logic             busy,
   output logic [IDXW:0]    count
);

   localparam int CW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE);
   localparam logic [CW-1:0]   DEB_LAST = CW'(DEBOUNCE - 1);
   localparam logic [IDXW-1:0] LAST     = IDXW'(DEPTH - 1);
   localparam logic [IDXW:0]   FULL     = (IDXW + 1)'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [1:0]         sync1_q, sync1_d;
   logic [1:0]         sync2_q, sync2_d;
   logic [1:0][CW-1:0] deb_cnt_q, deb_cnt_d;
   logic [1:0]         deb_lvl_q, deb_lvl_d;
   logic [1:0]         deb_prev_q, deb_prev_d;
   logic [WIDTH-1:0]   mem_q [DEPTH];
   logic [WIDTH-1:0]   mem_d [DEPTH];
   logic [DEPTH-1:0]   valid_q, valid_d;
   logic [IDXW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [IDXW:0]      count_q, count_d;
   logic [IDXW-1:0]    idx_q, idx_d;
   logic               found_q, found_d;
   logic [IDXW-1:0]    hit_q, hit_d;
   logic [WIDTH-1:0]   cmp_val_q, cmp_val_d;
   logic               st_pend_q, st_pend_d;
   logic [WIDTH-1:0]   st_buf_q, st_buf_d;
   logic               cmp_pend_q, cmp_pend_d;
   logic               result_q, result_d;
   logic               result_valid_q, result_valid_d;
   logic [IDXW-1:0]    match_idx_q, match_idx_d;

   logic               st_p;
   logic               cmp_p;
   logic               do_store;
   logic [WIDTH-1:0]   store_data;
   logic               hit_now;

   always_comb begin
      sync1_d    = pushbutton;
      sync2_d    = sync1_q;
      deb_prev_d = deb_lvl_q;
      deb_cnt_d  = '0;
      deb_lvl_d  = deb_lvl_q;
      for (int b = 0; b < 2; b++) begin
         if (sync2_q[b] != deb_lvl_q[b]) begin
            if (deb_cnt_q[b] == DEB_LAST) begin
               deb_lvl_d[b] = ~deb_lvl_q[b];
            end else begin
               deb_cnt_d[b] = deb_cnt_q[b] + 1'b1;
            end
         end
      end
   end

   assign st_p  = deb_lvl_q[1] & ~deb_prev_q[1];
   assign cmp_p = deb_lvl_q[0] & ~deb_prev_q[0];

   always_comb begin
      state_d        = state_q;
      idx_d          = idx_q;
      found_d        = found_q;
      hit_d          = hit_q;
      cmp_val_d      = cmp_val_q;
      st_pend_d      = st_pend_q;
      st_buf_d       = st_buf_q;
      cmp_pend_d     = cmp_pend_q;
      result_d       = result_q;
      match_idx_d    = match_idx_q;
      result_valid_d = 1'b0;
      do_store       = 1'b0;
      store_data     = test;
      hit_now        = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            // A buffered store goes first; a fresh press arriving alongside it is re-buffered.
            if (st_pend_q) begin
               do_store   = 1'b1;
               store_data = st_buf_q;
               if (st_p) begin
                  st_buf_d = test;
               end else begin
                  st_pend_d = 1'b0;
               end
            end else if (st_p) begin
               do_store = 1'b1;
            end
            if (cmp_p || cmp_pend_q) begin
               if (do_store) begin
                  cmp_pend_d = 1'b1;
               end else begin
                  cmp_pend_d = 1'b0;
                  cmp_val_d  = test;
                  idx_d      = '0;
                  found_d    = 1'b0;
                  hit_d      = '0;
                  state_d    = S_SCAN;
               end
            end
         end
         S_SCAN: begin
            hit_now = valid_q[idx_q] && (mem_q[idx_q] == cmp_val_q) && !found_q;
            if (hit_now) begin
               found_d = 1'b1;
               hit_d   = idx_q;
            end
            // Results are loaded on entry to DONE so they are visible alongside result_valid.
            if (idx_q == LAST) begin
               state_d        = S_DONE;
               result_valid_d = 1'b1;
               result_d       = found_q | hit_now;
               match_idx_d    = hit_now ? idx_q : hit_q;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if ((state_q != S_IDLE) && st_p) begin
         st_pend_d = 1'b1;
         st_buf_d  = test;
      end
   end

   always_comb begin
      mem_d    = mem_q;
      valid_d  = valid_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (do_store) begin
         mem_d[wr_ptr_q]   = store_data;
         valid_d[wr_ptr_q] = 1'b1;
         wr_ptr_d          = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
         count_d           = (count_q == FULL) ? count_q : count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_IDLE;
         sync1_q        <= '0;
         sync2_q        <= '0;
         deb_cnt_q      <= '0;
         deb_lvl_q      <= '0;
         deb_prev_q     <= '0;
         valid_q        <= '0;
         wr_ptr_q       <= '0;
         count_q        <= '0;
         idx_q          <= '0;
         found_q        <= 1'b0;
         hit_q          <= '0;
         cmp_val_q      <= '0;
         st_pend_q      <= 1'b0;
         st_buf_q       <= '0;
         cmp_pend_q     <= 1'b0;
         result_q       <= 1'b0;
         result_valid_q <= 1'b0;
         match_idx_q    <= '0;
      end else begin
         state_q        <= state_d;
         sync1_q        <= sync1_d;
         sync2_q        <= sync2_d;
         deb_cnt_q      <= deb_cnt_d;
         deb_lvl_q      <= deb_lvl_d;
         deb_prev_q     <= deb_prev_d;
         valid_q        <= valid_d;
         wr_ptr_q       <= wr_ptr_d;
         count_q        <= count_d;
         idx_q          <= idx_d;
         found_q        <= found_d;
         hit_q          <= hit_d;
         cmp_val_q      <= cmp_val_d;
         st_pend_q      <= st_pend_d;
         st_buf_q       <= st_buf_d;
         cmp_pend_q     <= cmp_pend_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
         match_idx_q    <= match_idx_d;
      end
   end

   assign result       = result_q;
   assign result_valid = result_valid_q;
   assign match_idx    = match_idx_q;
   assign busy         = (state_q == S_SCAN);
   assign count        = count_q;

endmodule

// File: doc/eqn_match_store.md
Name: eqn_match_store

Overview:
- Parametrised successor to the 4-bit pushbutton equality checker. It stores up to DEPTH operand words captured from the `test` switches on a debounced "store" button press.
- On a debounced "compare" button press, it scans all stored words sequentially and reports whether the current `test` value equals any of them, and which slot matched first.
- It sits between the board switch/button inputs and the LED/result logic of the lab datapath.

Parameters:
- WIDTH, 4: width of `test` and of each stored word.
- DEPTH, 4: number of storage slots. Must be >= 1.
- DEBOUNCE, 16: consecutive stable cycles required before a synchronised button level is accepted. Must be >= 1.
- IDXW, 2: width of `match_idx` and of `count` minus 1. Must satisfy 2^IDXW >= DEPTH.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- test  in  WIDTH  operand switches.
- pushbutton  in  2  raw buttons: [1] = store, [0] = compare. Asynchronous, bouncy.
- result  out  1  1 = last compare found a match.
- result_valid  out  1  one-cycle pulse when `result` and `match_idx` update.
- match_idx  out  IDXW  lowest slot index that matched (0 if no match).
- busy  out  1  high while a compare scan is running.
- count  out  IDXW+1  number of valid stored words, saturating at DEPTH.

Behaviour:
- Reset (synchronous, active-high): all outputs are 0. The following are also cleared: write pointer, count, slot valid bits, synchronisers, debounce counters, debounced levels, pending flags. FSM = IDLE. Slot data contents are don't-care. Reset asserted mid-scan aborts the scan with no result_valid.
- Button path, per bit:
  - 2-flop synchroniser.
  - Debounce counter: increments while the synchronised level differs from the debounced level, otherwise clears to 0. When it reaches DEBOUNCE, the debounced level flips and the counter clears.
  - A rising edge of the debounced level gives a one-cycle pulse: st_p for bit 1, cmp_p for bit 0.
  - A raw rise held steady gives its pulse exactly 2+DEBOUNCE cycles after the first sampling edge.
  - Glitches shorter than DEBOUNCE cycles produce no pulse. Release produces no pulse.
- Store (st_p):
  - `test` is sampled in the pulse cycle into the slot at wr_ptr, and that slot's valid bit is set.
  - wr_ptr advances modulo DEPTH. After DEPTH stores it wraps and overwrites the oldest slot.
  - count increments, saturating at DEPTH.
- Compare FSM: IDLE, SCAN, DONE.
  - IDLE + cmp_p: latch `test` into cmp_val, set scan index i=0, found=0, go to SCAN.
  - SCAN: busy=1; one slot per cycle. If slot i is valid, slot i == cmp_val, and found=0, then set found=1 and hit=i. If i==DEPTH-1, go to DONE; otherwise i++. Duration is always DEPTH cycles, independent of matches.
  - DONE: result<=found, match_idx<=hit (0 if found=0), result_valid pulses for this one cycle, go to IDLE. busy=0 in DONE.
  - result and match_idx hold until the next DONE or reset.
- Simultaneous and overlapping events:
  - st_p and cmp_p in the same IDLE cycle: the store writes first, and the compare is recorded as pending and starts in the next cycle. The new word is therefore included in the scan.
  - st_p during SCAN/DONE: `test` is captured into a one-deep pending store buffer and written in the first IDLE cycle. A second st_p while the buffer is full overwrites the buffered word; the latest wins.
  - cmp_p during SCAN/DONE is ignored, with no queuing.
  - A pending store and a pending compare in the same IDLE cycle follow the same rule: store first, compare next cycle.
- Equality is a full WIDTH-bit compare. No X-propagation on empty slots; valid bits gate the compare.
- Compare latency from cmp_p (IDLE, nothing pending) to result_valid: DEPTH+1 cycles.

Test Plan (WIDTH=4, DEPTH=4, DEBOUNCE=4):
- Reset held 3 cycles, then released -> all outputs 0, count=0. A compare with an empty store gives result_valid after 5 cycles with result=0 and match_idx=0.
- Store 4'b0000 via a clean press of pushbutton[1], then compare with test=4'b0000 -> count=1, result=1, match_idx=0. Compare again with test=4'b0101 -> result=0.
- Press pulses of 1, 2 and 3 cycles on pushbutton[1] -> no store, count stays unchanged. A 4-cycle stable press -> exactly one store, with st_p 6 cycles after the rise.
- Store 3,5,7,9, then store 4'hB -> wrap overwrites slot 0 and count=4. Compare with 3 -> result=0. Compare with B -> result=1, match_idx=0. Compare with 9 -> match_idx=3.
- Both buttons rise together with test=4'hE -> store first, then the scan. Result is result=1 with the matching slot index, and result_valid arrives 6 cycles after the pulses.
- Store press during SCAN with test=4'h6 -> the scan result is unaffected, the word is written after DONE, and a following compare with 6 returns result=1. Reset asserted mid-SCAN -> no result_valid, and all outputs are 0 the next cycle.
